// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: shared mode encoding for the jk_bank register/counter/shifter.
package jk_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK  = 2'b00;
    localparam mode_t MODE_UP  = 2'b01;
    localparam mode_t MODE_DN  = 2'b10;
    localparam mode_t MODE_SHL = 2'b11;

endpackage

// File: rtl/jk_bank_jk_cell.sv
// jk_cell: combinational next-state function of a single JK flip-flop.
module jk_cell (
    input  logic q,
    input  logic j,
    input  logic k,
    output logic q_next
);

    assign q_next = (j & ~q) | (~k & q);

endmodule

// File: rtl/jk_bank.sv
// jk_bank: WIDTH JK flip-flops run as JK register, up/down counter or shift-left register.
// Define JK_BANK_SAT_EN to make the count modes saturate instead of wrapping.
module jk_bank
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    logic [WIDTH-1:0] t_up, t_dn, cj, ck, cell_q, q_nxt;
    logic             blocked;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            // Toggle terms are flat reductions so no bit depends on its neighbour's term.
            if (i == 0) begin : g_lsb
                assign t_up[i] = 1'b1;
                assign t_dn[i] = 1'b1;
            end else begin : g_upper
                assign t_up[i] = &q[i-1:0];
                assign t_dn[i] = ~|q[i-1:0];
            end
            assign cj[i] = (mode == MODE_JK) ? j[i] : (mode == MODE_UP) ? t_up[i] : t_dn[i];
            assign ck[i] = (mode == MODE_JK) ? k[i] : (mode == MODE_UP) ? t_up[i] : t_dn[i];
            jk_cell u_cell (
                .q     (q[i]),
                .j     (cj[i]),
                .k     (ck[i]),
                .q_next(cell_q[i])
            );
        end
    endgenerate

    assign blocked = ((mode == MODE_UP) && (&q)) || ((mode == MODE_DN) && (~|q));

`ifdef JK_BANK_SAT_EN
    assign q_nxt = (mode == MODE_SHL) ? {q[WIDTH-2:0], j[0]} : blocked ? q : cell_q;
`else
    assign q_nxt = (mode == MODE_SHL) ? {q[WIDTH-2:0], j[0]} : cell_q;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= blocked;
        end
    end

endmodule
